// File: rtl/dmem_access_ctrl.sv
// Sequencer/arbiter in front of a word-only data memory: sub-word loads, RMW sub-word stores.
// Optional macro DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed CPU priority.
module dmem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        cpu_read,
  input  logic [2:0]        cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_busywait,
  input  logic [3:0]        acc_read,
  input  logic [2:0]        acc_write,
  input  logic [ADDR_W-1:0] acc_address,
  input  logic [DATA_W-1:0] acc_writedata,
  output logic [DATA_W-1:0] acc_readdata,
  output logic              acc_busywait,
  output logic [3:0]        mem_read,
  output logic [2:0]        mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic              misalign_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              grant_q, grant_d;   // 1 = acc owns the transaction
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        size_q, size_d;
  logic              store_q, store_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] acc_rdata_q, acc_rdata_d;

  logic cpu_req, acc_req, any_req, pick_acc, sel_reject;
  logic [3:0]        sel_read;
  logic [2:0]        sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [1:0] size, input logic [1:0] lane,
                                              input logic [31:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (size == 2'b00) r[{lane, 3'b000} +: 8] = d[7:0];
    else if (lane[1])  r[31:16] = d[15:0];
    else               r[15:0]  = d[15:0];
    return r;
  endfunction

  function automatic logic reject(input logic [3:0] rd, input logic [2:0] wr, input logic [1:0] a);
    logic r;
    r = 1'b0;
    if (rd[3] && wr[2]) r = 1'b1;
    else if (rd[3]) begin
      case (rd[2:0])
        3'b000, 3'b100: r = 1'b0;
        3'b001, 3'b101: r = a[0];
        3'b010:         r = (a != 2'b00);
        default:        r = 1'b1;
      endcase
    end else if (wr[2]) begin
      case (wr[1:0])
        2'b00:   r = 1'b0;
        2'b01:   r = a[0];
        2'b10:   r = (a != 2'b00);
        default: r = 1'b1;
      endcase
    end
    return r;
  endfunction

  assign cpu_req = cpu_read[3] | cpu_write[2];
  assign acc_req = acc_read[3] | acc_write[2];
  assign any_req = cpu_req | acc_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;  // 1 = acc was granted last
  assign pick_acc = acc_req & (~cpu_req | ~last_q);
  assign last_d   = (state_q == S_IDLE && any_req) ? pick_acc : last_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign pick_acc = acc_req & ~cpu_req;
`endif

  assign sel_read   = pick_acc ? acc_read      : cpu_read;
  assign sel_write  = pick_acc ? acc_write     : cpu_write;
  assign sel_addr   = pick_acc ? acc_address   : cpu_address;
  assign sel_wdata  = pick_acc ? acc_writedata : cpu_writedata;
  assign sel_reject = reject(sel_read, sel_write, sel_addr[1:0]);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    size_d      = size_q;
    store_d     = store_q;
    err_d       = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    acc_rdata_d = acc_rdata_q;
    case (state_q)
      S_IDLE: if (any_req) begin
        grant_d = pick_acc;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
        f3_d    = sel_read[2:0];
        size_d  = sel_write[1:0];
        store_d = sel_write[2];
        if (sel_reject) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (pick_acc) acc_rdata_d = '0;
          else          cpu_rdata_d = '0;
        end else if (sel_write[2] && sel_write[1:0] == 2'b10) begin
          state_d = S_WR;
        end else begin
          state_d = S_RD;
        end
      end
      S_RD: if (!mem_busywait) state_d = S_CAP;
      S_CAP: begin
        if (store_q) begin
          wdata_d = store_merge(size_q, addr_q[1:0], mem_readdata, wdata_q);
          state_d = S_WR;
        end else begin
          if (grant_q) acc_rdata_d = load_extract(f3_q, addr_q[1:0], mem_readdata);
          else         cpu_rdata_d = load_extract(f3_q, addr_q[1:0], mem_readdata);
          state_d = S_DONE;
        end
      end
      S_WR:    if (!mem_busywait) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      size_q      <= '0;
      store_q     <= 1'b0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      acc_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      size_q      <= size_d;
      store_q     <= store_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      acc_rdata_q <= acc_rdata_d;
    end
  end

  assign mem_read      = (state_q == S_RD) ? 4'b1010 : 4'b0000;
  assign mem_write     = (state_q == S_WR) ? 3'b110  : 3'b000;
  assign mem_address   = (state_q == S_RD || state_q == S_WR) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_writedata = (state_q == S_WR) ? wdata_q : '0;
  assign misalign_err  = err_q;
  assign cpu_readdata  = cpu_rdata_q;
  assign acc_readdata  = acc_rdata_q;
  assign cpu_busywait  = cpu_req & ~(state_q == S_DONE && !grant_q);
  assign acc_busywait  = acc_req & ~(state_q == S_DONE && grant_q);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a one-cycle-latency word memory model and a readdata scoreboard.
// Handshake: a requester holds its inputs while busywait=1; readdata is valid the cycle busywait drops.
module tb_dmem_access_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cpu_read = '0, acc_read = '0;
  logic [2:0]  cpu_write = '0, acc_write = '0;
  logic [31:0] cpu_address = '0, cpu_writedata = '0, acc_address = '0, acc_writedata = '0;
  logic [31:0] cpu_readdata, acc_readdata;
  logic        cpu_busywait, acc_busywait;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_address, mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        mem_busywait = 1'b0;
  logic        misalign_err;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_m [0:63];

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata), .cpu_busywait(cpu_busywait),
    .acc_read(acc_read), .acc_write(acc_write), .acc_address(acc_address),
    .acc_writedata(acc_writedata), .acc_readdata(acc_readdata), .acc_busywait(acc_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .misalign_err(misalign_err)
  );

  always #5 clock = ~clock;

  // Word memory: read data appears the cycle after an accepted read.
  always @(posedge clock) begin
    if (mem_write == 3'b110 && !mem_busywait) mem_m[mem_address[7:2]] <= mem_writedata;
    if (mem_read == 4'b1010 && !mem_busywait) mem_readdata <= mem_m[mem_address[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    cpu_read = '0; cpu_write = '0; acc_read = '0; acc_write = '0;
    mem_busywait = 1'b0;
  endtask

  // Monitors a transaction whose inputs are already applied at the current negedge (cycle 0).
  task automatic run_wait(input string tag, input bit use_acc, input bit chk_rd,
                          input int exp_lat, input int exp_rd, input int exp_wr,
                          input logic [31:0] exp_wa, input bit exp_err, input int stall);
    int cyc, rd_c, wr_c;
    logic [31:0] wr_a, obs_rd, exp_rd_val;
    logic obs_err;
    bit done;
    cyc = 0; rd_c = -1; wr_c = -1; wr_a = '0; done = 0; obs_rd = '0; obs_err = 1'b0;
    while (!done && cyc < 20) begin
      #1;
      mem_busywait = (cyc == stall);
      if (mem_read != 4'b0 && rd_c < 0) rd_c = cyc;
      if (mem_write != 3'b0 && wr_c < 0) begin wr_c = cyc; wr_a = mem_address; end
      if (!(use_acc ? acc_busywait : cpu_busywait)) begin
        done = 1;
        obs_rd = use_acc ? acc_readdata : cpu_readdata;
        obs_err = misalign_err;
      end else begin
        @(negedge clock);
        cyc++;
      end
    end
    clear_inputs();
    exp_rd_val = exp_q.pop_front();
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_rd_cycle"}, 32'(rd_c), 32'(exp_rd));
    chk({tag, "_wr_cycle"}, 32'(wr_c), 32'(exp_wr));
    if (exp_wr >= 0) chk({tag, "_wr_addr"}, wr_a, exp_wa);
    chk({tag, "_misalign"}, {31'b0, obs_err}, {31'b0, exp_err});
    if (chk_rd) chk({tag, "_rdata"}, obs_rd, exp_rd_val);
  endtask

  task automatic txn(input string tag, input bit use_acc, input logic [3:0] rd, input logic [2:0] wr,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input int exp_lat, input int exp_rd, input int exp_wr, input bit exp_err,
                     input int stall);
    @(negedge clock);
    if (use_acc) begin
      acc_read = rd; acc_write = wr; acc_address = addr; acc_writedata = wdata;
    end else begin
      cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = wdata;
    end
    exp_q.push_back(exp_rdata);
    run_wait(tag, use_acc, rd[3] | exp_err, exp_lat, exp_rd, exp_wr,
             {addr[31:2], 2'b00}, exp_err, stall);
  endtask

  // CPU LW and acc SW raised together; checks completion cycle of each port.
  task automatic arb_both(input string tag, input logic [31:0] acc_data, input logic [31:0] exp_cpu,
                          input int exp_cd, input int exp_ad);
    int cyc, cd, ad;
    logic [31:0] obs;
    @(negedge clock);
    cpu_read = 4'b1010; cpu_address = 32'h20;
    acc_write = 3'b110; acc_address = 32'h24; acc_writedata = acc_data;
    exp_q.push_back(exp_cpu);
    cyc = 0; cd = -1; ad = -1; obs = '0;
    while ((cd < 0 || ad < 0) && cyc < 30) begin
      #1;
      if (cd < 0 && !cpu_busywait) begin cd = cyc; obs = cpu_readdata; cpu_read = '0; end
      if (ad < 0 && !acc_busywait) begin ad = cyc; acc_write = '0; end
      if (cd < 0 || ad < 0) begin @(negedge clock); cyc++; end
    end
    clear_inputs();
    chk({tag, "_cpu_done"}, 32'(cd), 32'(exp_cd));
    chk({tag, "_acc_done"}, 32'(ad), 32'(exp_ad));
    chk({tag, "_cpu_rdata"}, obs, exp_q.pop_front());
  endtask

  initial begin
    int cyc;
    // Reset state, and combinational busywait while reset is held.
    repeat (2) @(negedge clock);
    #1;
    chk("rst_mem_read", {28'b0, mem_read}, 32'h0);
    chk("rst_mem_write", {29'b0, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_writedata, 32'h0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'h0);
    chk("rst_cpu_rdata", cpu_readdata, 32'h0);
    chk("rst_acc_rdata", acc_readdata, 32'h0);
    cpu_write = 3'b110;
    #1 chk("rst_busywait_req", {31'b0, cpu_busywait}, 32'h1);
    cpu_write = 3'b000;
    @(negedge clock);
    reset = 1'b1;

    txn("sw_10", 0, 4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, 32'h0, 2, -1, 1, 0, -1);
    chk("mem_after_sw", mem_m[4], 32'hDEADBEEF);
    txn("lb_13", 0, 4'b1000, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 3, 1, -1, 0, -1);
    txn("lbu_13", 0, 4'b1100, 3'b000, 32'h13, 32'h0, 32'h000000DE, 3, 1, -1, 0, -1);
    txn("lh_12", 0, 4'b1001, 3'b000, 32'h12, 32'h0, 32'hFFFFDEAD, 3, 1, -1, 0, -1);
    txn("sb_11", 0, 4'b0000, 3'b100, 32'h11, 32'h55, 32'h0, 4, 1, 3, 0, -1);
    chk("mem_after_sb", mem_m[4], 32'hDEAD55EF);
    txn("lw_mis_22", 0, 4'b1010, 3'b000, 32'h22, 32'h0, 32'h0, 1, -1, -1, 1, -1);
    txn("acc_lhu_12", 1, 4'b1101, 3'b000, 32'h12, 32'h0, 32'h0000DEAD, 3, 1, -1, 0, -1);
    txn("rd_and_wr", 0, 4'b1010, 3'b110, 32'h10, 32'h0, 32'h0, 1, -1, -1, 1, -1);
    txn("lw_stall", 0, 4'b1010, 3'b000, 32'h10, 32'h0, 32'hDEAD55EF, 4, 1, -1, 0, 1);

    // SH interrupted by reset in WR, then replayed in full after release.
    @(negedge clock);
    cpu_write = 3'b101; cpu_address = 32'h12; cpu_writedata = 32'h00001234;
    repeat (3) @(negedge clock);
    #1 chk("sh_in_wr", {29'b0, mem_write}, 32'h6);
    reset = 1'b0;
    #1 chk("sh_rst_mem_write", {29'b0, mem_write}, 32'h0);
    repeat (2) @(negedge clock);
    chk("sh_no_partial", mem_m[4], 32'hDEAD55EF);
    reset = 1'b1;
    exp_q.push_back(32'h0);
    run_wait("sh_replay", 0, 0, 4, 1, 3, 32'h10, 0, -1);
    chk("mem_after_sh", mem_m[4], 32'h123455EF);

    txn("sw_20", 0, 4'b0000, 3'b110, 32'h20, 32'h12345678, 32'h0, 2, -1, 1, 0, -1);
    txn("acc_lw_10", 1, 4'b1010, 3'b000, 32'h10, 32'h0, 32'h123455EF, 3, 1, -1, 0, -1);
    arb_both("arb_a", 32'hCAFEF00D, 32'h12345678, 3, 6);
    txn("lw_24", 0, 4'b1010, 3'b000, 32'h24, 32'h0, 32'hCAFEF00D, 3, 1, -1, 0, -1);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    arb_both("arb_b", 32'h0BADC0DE, 32'h12345678, 6, 2);
`else
    arb_both("arb_b", 32'h0BADC0DE, 32'h12345678, 3, 6);
`endif
    txn("acc_lw_24", 1, 4'b1010, 3'b000, 32'h24, 32'h0, 32'h0BADC0DE, 3, 1, -1, 0, -1);

    cyc = 0;
    repeat (2) @(negedge clock);
    chk("idle_busywait", {30'b0, cpu_busywait, acc_busywait}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
